// File: rtl/aes_block_load_ctrl_if.sv
// Handshake bundle for aes_block_load_ctrl.
//   master : the side producing input words and consuming blocks (driver of in_valid,
//            in_last, blk_ready).
//   slave  : the sequencer itself; produces in_ready, shift-register strobes and
//            block status.
// CNT_W must equal $clog2(NUM_BYTES_OUT/NUM_BYTES_IN + 1) of the attached sequencer.
interface aes_block_load_ctrl_if #(
    parameter int unsigned CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic             sr_shift_enable;
    logic             sr_pad_sel;
    logic             blk_valid;
    logic             blk_ready;
    logic             blk_last;
    logic [CNT_W-1:0] blk_pad_words;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output in_valid, in_last, blk_ready,
        input  in_ready, sr_shift_enable, sr_pad_sel, blk_valid, blk_last,
               blk_pad_words, word_cnt
    );

    modport slave (
        input  in_valid, in_last, blk_ready,
        output in_ready, sr_shift_enable, sr_pad_sel, blk_valid, blk_last,
               blk_pad_words, word_cnt
    );
endinterface

// File: rtl/aes_block_load_ctrl.sv
// Sequencer for the word-serial-to-block shift register in the AES input path.
// Accepts words over in_valid/in_ready, strobes the shift register, zero-pads a short
// final block and presents the full block to the core over blk_valid/blk_ready.
// Holds no data; the block is the shift register's data_out.
// Ports:
//   clk    : system clock
//   n_rst  : synchronous active-low reset; forces every output low while asserted
//   abort  : synchronous discard of a partial or held block
//   bus    : slave side of aes_block_load_ctrl_if (input word handshake, shift-register
//            strobes, block handshake and status, word_cnt)
module aes_block_load_ctrl #(
    parameter int unsigned NUM_BYTES_IN  = 4,
    parameter int unsigned NUM_BYTES_OUT = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 abort,
    aes_block_load_ctrl_if.slave bus
);
    localparam int unsigned WORDS = NUM_BYTES_OUT / NUM_BYTES_IN;
    localparam int unsigned CNT_W = $clog2(WORDS + 1);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    if ((NUM_BYTES_OUT % NUM_BYTES_IN) != 0 || WORDS < 2) begin : g_param_check
        $fatal(1, "aes_block_load_ctrl: NUM_BYTES_OUT must be a multiple >= 2 of NUM_BYTES_IN");
    end

    typedef enum logic [1:0] {StFill, StPad, StFull} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             blk_last_q, blk_last_d;
    logic [CNT_W-1:0] pad_words_q, pad_words_d;
    logic             in_ready_c, shift_c, pad_sel_c;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= StFill;
            word_cnt_q  <= '0;
            blk_last_q  <= 1'b0;
            pad_words_q <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            blk_last_q  <= blk_last_d;
            pad_words_q <= pad_words_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        blk_last_d  = blk_last_q;
        pad_words_d = pad_words_q;
        in_ready_c  = 1'b0;
        shift_c     = 1'b0;
        pad_sel_c   = 1'b0;

        if (abort) begin
            // Drop everything, including a held block, without a handshake.
            state_d     = StFill;
            word_cnt_d  = '0;
            blk_last_d  = 1'b0;
            pad_words_d = '0;
        end else begin
            unique case (state_q)
                StFill: begin
                    in_ready_c = 1'b1;
                    if (bus.in_valid) begin
                        shift_c    = 1'b1;
                        word_cnt_d = word_cnt_q + ONE;
                        if (word_cnt_q == LAST_IDX) begin
                            state_d     = StFull;
                            blk_last_d  = bus.in_last;
                            pad_words_d = '0;
                        end else if (bus.in_last) begin
                            state_d     = StPad;
                            blk_last_d  = 1'b1;
                            pad_words_d = LAST_IDX - word_cnt_q;
                        end
                    end
                end
                StPad: begin
                    shift_c    = 1'b1;
                    pad_sel_c  = 1'b1;
                    word_cnt_d = word_cnt_q + ONE;
                    if (word_cnt_q == LAST_IDX) begin
                        state_d = StFull;
                    end
                end
                StFull: begin
                    // Input is only admitted when the held block leaves this same cycle.
                    in_ready_c = bus.blk_ready;
                    if (bus.blk_ready) begin
                        if (bus.in_valid) begin
                            shift_c    = 1'b1;
                            word_cnt_d = ONE;
                            if (bus.in_last) begin
                                state_d     = StPad;
                                blk_last_d  = 1'b1;
                                pad_words_d = LAST_IDX;
                            end else begin
                                state_d = StFill;
                            end
                        end else begin
                            state_d    = StFill;
                            word_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d    = StFill;
                    word_cnt_d = '0;
                end
            endcase
        end
    end

    // Everything is held low while reset is asserted, even before the first edge.
    always_comb begin
        bus.in_ready        = n_rst & in_ready_c;
        bus.sr_shift_enable = n_rst & shift_c;
        bus.sr_pad_sel      = n_rst & pad_sel_c;
        bus.blk_valid       = n_rst & (state_q == StFull);
        bus.blk_last        = n_rst & blk_last_q;
        bus.blk_pad_words   = n_rst ? pad_words_q : '0;
        bus.word_cnt        = n_rst ? word_cnt_q : '0;
    end
endmodule

// File: tb/tb_aes_block_load_ctrl.sv
module tb_aes_block_load_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic n_rst;
    logic abort;

    aes_block_load_ctrl_if #(.CNT_W(3)) bus ();

    aes_block_load_ctrl #(
        .NUM_BYTES_IN (4),
        .NUM_BYTES_OUT(16)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .abort(abort),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;
    int shifts   = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // Model: words loaded into the current block, pad words still to be inserted,
    // and the status latched for the block being built or held.
    int m_cnt   = 0;
    int m_pads  = 0;
    int m_last  = 0;
    int m_padw  = 0;
    bit m_valid = 0;

    // Inputs change just after posedge; compare and advance the model at negedge.
    always @(negedge clk) begin
        int e_rdy, e_shf, e_psel;
        if (!n_rst) begin
            check("rst_in_ready", int'(bus.in_ready), 0);
            check("rst_shift", int'(bus.sr_shift_enable), 0);
            check("rst_pad_sel", int'(bus.sr_pad_sel), 0);
            check("rst_blk_valid", int'(bus.blk_valid), 0);
            check("rst_blk_last", int'(bus.blk_last), 0);
            check("rst_pad_words", int'(bus.blk_pad_words), 0);
            check("rst_word_cnt", int'(bus.word_cnt), 0);
            m_cnt = 0; m_pads = 0; m_last = 0; m_padw = 0; m_valid = 1;
        end else if (m_valid) begin
            if (abort) begin
                e_rdy = 0; e_shf = 0; e_psel = 0;
            end else if (m_pads > 0) begin
                e_rdy = 0; e_shf = 1; e_psel = 1;
            end else if (m_cnt == W) begin
                e_rdy = int'(bus.blk_ready);
                e_shf = int'(bus.blk_ready & bus.in_valid);
                e_psel = 0;
            end else begin
                e_rdy = 1; e_shf = int'(bus.in_valid); e_psel = 0;
            end
            check("in_ready", int'(bus.in_ready), e_rdy);
            check("shift", int'(bus.sr_shift_enable), e_shf);
            check("pad_sel", int'(bus.sr_pad_sel), e_psel);
            check("blk_valid", int'(bus.blk_valid), int'(m_cnt == W));
            check("blk_last", int'(bus.blk_last), m_last);
            check("pad_words", int'(bus.blk_pad_words), m_padw);
            check("word_cnt", int'(bus.word_cnt), m_cnt);
            if (bus.sr_shift_enable) shifts++;

            if (abort) begin
                m_cnt = 0; m_pads = 0; m_last = 0; m_padw = 0;
            end else if (m_pads > 0) begin
                m_cnt++; m_pads--;
            end else if (m_cnt == W) begin
                if (bus.blk_ready) begin
                    m_cnt = bus.in_valid ? 1 : 0;
                    if (bus.in_valid && bus.in_last) begin
                        m_pads = W - 1; m_last = 1; m_padw = W - 1;
                    end
                end
            end else if (bus.in_valid) begin
                m_cnt++;
                if (m_cnt == W) begin
                    m_last = int'(bus.in_last); m_padw = 0;
                end else if (bus.in_last) begin
                    m_pads = W - m_cnt; m_last = 1; m_padw = m_pads;
                end
            end
        end
    end

    task automatic step(input bit r, input bit a, input bit v, input bit l, input bit br);
        n_rst         = r;
        abort         = a;
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.blk_ready = br;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("lit_rst_word_cnt", int'(bus.word_cnt), 0);
        check("lit_rst_in_ready", int'(bus.in_ready), 0);

        // Four back-to-back words.
        base = shifts;
        repeat (4) step(1, 0, 1, 0, 1);
        check("lit_full_valid", int'(bus.blk_valid), 1);
        check("lit_full_cnt", int'(bus.word_cnt), 4);
        check("lit_full_last", int'(bus.blk_last), 0);
        check("lit_full_pad", int'(bus.blk_pad_words), 0);
        check("lit_full_shifts", shifts - base, 4);
        step(1, 0, 0, 0, 1);
        check("lit_consumed_cnt", int'(bus.word_cnt), 0);
        check("lit_consumed_valid", int'(bus.blk_valid), 0);

        // Last on word 2: two pad cycles, in_valid held high but refused.
        base = shifts;
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        check("lit_pad_cnt", int'(bus.word_cnt), 2);
        check("lit_pad_words", int'(bus.blk_pad_words), 2);
        check("lit_pad_last", int'(bus.blk_last), 1);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        check("lit_padded_valid", int'(bus.blk_valid), 1);
        check("lit_padded_shifts", shifts - base, 4);

        // Stall 3 cycles in FULL, then handoff.
        base = shifts;
        repeat (3) step(1, 0, 1, 0, 0);
        check("lit_stall_cnt", int'(bus.word_cnt), 4);
        check("lit_stall_shifts", shifts - base, 0);
        step(1, 0, 1, 0, 1);
        check("lit_handoff_cnt", int'(bus.word_cnt), 1);
        check("lit_handoff_valid", int'(bus.blk_valid), 0);

        // Abort after 3 words.
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        base = shifts;
        step(1, 1, 1, 0, 0);
        check("lit_abort_cnt", int'(bus.word_cnt), 0);
        check("lit_abort_shifts", shifts - base, 0);
        check("lit_abort_last", int'(bus.blk_last), 0);
        repeat (3) step(1, 0, 1, 0, 0);
        check("lit_abort_3w_valid", int'(bus.blk_valid), 0);
        step(1, 0, 1, 0, 0);
        check("lit_abort_4w_valid", int'(bus.blk_valid), 1);
        step(1, 0, 0, 0, 1);

        // Reset in the middle of padding.
        step(1, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        check("lit_midrst_shift", int'(bus.sr_shift_enable), 0);
        check("lit_midrst_pad_sel", int'(bus.sr_pad_sel), 0);
        step(1, 0, 0, 0, 0);
        check("lit_rel_in_ready", int'(bus.in_ready), 1);
        check("lit_rel_cnt", int'(bus.word_cnt), 0);

        // Last on word 4 with the core stalled: no padding.
        base = shifts;
        repeat (3) step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        check("lit_last4_last", int'(bus.blk_last), 1);
        check("lit_last4_pad", int'(bus.blk_pad_words), 0);
        check("lit_last4_valid", int'(bus.blk_valid), 1);
        step(1, 0, 0, 0, 0);
        check("lit_last4_shifts", shifts - base, 4);

        // Handoff carrying last: three pad words follow.
        step(1, 0, 1, 1, 1);
        check("lit_ho_last_pad", int'(bus.blk_pad_words), 3);
        repeat (3) step(1, 0, 0, 0, 0);
        check("lit_ho_last_valid", int'(bus.blk_valid), 1);

        // Abort drops a held block; last without valid is ignored.
        step(1, 1, 0, 0, 0);
        check("lit_drop_valid", int'(bus.blk_valid), 0);
        step(1, 0, 0, 1, 0);
        check("lit_ign_last_cnt", int'(bus.word_cnt), 0);

        // Streaming with blk_ready high: one block every 4 cycles.
        base = shifts;
        repeat (12) step(1, 0, 1, 0, 1);
        check("lit_stream_shifts", shifts - base, 12);
        check("lit_stream_valid", int'(bus.blk_valid), 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end
endmodule
